// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - instruction fields, flags and control lines between mc_control_unit and the datapath
interface mc_control_unit_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       IRWrite;
  logic       PCEn;
  logic       MemWrite;
  logic       RegWrite;
  logic       IorD;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  modport master (
    input  Op, Funct, Zero,
    output IRWrite, PCEn, MemWrite, RegWrite, IorD, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, PCSrc, ALUControl, State
  );

  modport slave (
    output Op, Funct, Zero,
    input  IRWrite, PCEn, MemWrite, RegWrite, IorD, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, PCSrc, ALUControl, State
  );
endinterface

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle MIPS Moore control FSM plus ALU decoder; MC_BNE_EN adds bne
// Enables are forced low while RST is high; State always shows the registered value.
module mc_control_unit (
  input  logic               CLK,
  input  logic               RST,
  mc_control_unit_if.master  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
`ifdef MC_BNE_EN
    , BNEEX = 4'd12
`endif
  } state_t;

  state_t state;
  state_t state_next;

  logic       ir_write, pc_write, mem_write, reg_write;
  logic       iord, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic       branch;
  logic       legal;
  logic [2:0] alu_ctl;
  logic       pc_en;
`ifdef MC_BNE_EN
  logic       branch_ne;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:   state_next = DECODE;
      DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_next = BNEEX;
`endif
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:  state_next = (bus.Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_next = MEMWB;
      RTYPEEX: state_next = RTYPEWB;
      ADDIEX:  state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = 2'b00;
    branch     = 1'b0;
    legal      = 1'b1;
`ifdef MC_BNE_EN
    branch_ne  = 1'b0;
`endif
    case (state)
      FETCH:   begin ir_write = 1'b1; pc_write = 1'b1; alu_src_b = 2'b01; end
      DECODE:  alu_src_b = 2'b11;
      MEMADR:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      MEMRD:   iord = 1'b1;
      MEMWB:   begin mem_to_reg = 1'b1; reg_write = 1'b1; end
      MEMWR:   begin iord = 1'b1; mem_write = 1'b1; end
      RTYPEEX: begin alu_src_a = 1'b1; alu_op = 2'b10; end
      RTYPEWB: begin reg_dst = 1'b1; reg_write = 1'b1; end
      BEQEX:   begin alu_src_a = 1'b1; alu_op = 2'b01; pc_src = 2'b01; branch = 1'b1; end
      ADDIEX:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      ADDIWB:  reg_write = 1'b1;
      JEX:     begin pc_src = 2'b10; pc_write = 1'b1; end
`ifdef MC_BNE_EN
      BNEEX:   begin alu_src_a = 1'b1; alu_op = 2'b01; pc_src = 2'b01; branch_ne = 1'b1; end
`endif
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctl = 3'b010;
    case (alu_op)
      2'b01: alu_ctl = 3'b110;
      2'b10: begin
        case (bus.Funct)
          6'b100010: alu_ctl = 3'b110;
          6'b100100: alu_ctl = 3'b000;
          6'b100101: alu_ctl = 3'b001;
          6'b101010: alu_ctl = 3'b111;
          default:   alu_ctl = 3'b010;
        endcase
      end
      default: alu_ctl = 3'b010;
    endcase
  end

  // Zero feeds PCEn combinationally so a taken branch loads the PC in the same cycle.
  always_comb begin
    pc_en = pc_write | (branch & bus.Zero);
`ifdef MC_BNE_EN
    pc_en = pc_en | (branch_ne & ~bus.Zero);
`endif
  end

  always_comb begin
    bus.IRWrite    = 1'b0;
    bus.PCEn       = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.IorD       = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.PCSrc      = 2'b00;
    bus.ALUControl = 3'b000;
    if (!RST && legal) begin
      bus.IRWrite    = ir_write;
      bus.PCEn       = pc_en;
      bus.MemWrite   = mem_write;
      bus.RegWrite   = reg_write;
      bus.IorD       = iord;
      bus.RegDst     = reg_dst;
      bus.MemtoReg   = mem_to_reg;
      bus.ALUSrcA    = alu_src_a;
      bus.ALUSrcB    = alu_src_b;
      bus.PCSrc      = pc_src;
      bus.ALUControl = alu_ctl;
    end
  end

  assign bus.State = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - table-driven and randomized bench for mc_control_unit
module tb_mc_control_unit;

  logic CLK = 1'b0;
  logic RST;

  mc_control_unit_if bus ();

  mc_control_unit dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       ir;
    logic       pcen;
    logic       memw;
    logic       regw;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic [2:0] alu;
  } outs_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         len;
    logic [23:0] seq;
    logic [2:0] alu_r;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic outs_t actual_outs();
    outs_t o;
    o.ir       = bus.IRWrite;
    o.pcen     = bus.PCEn;
    o.memw     = bus.MemWrite;
    o.regw     = bus.RegWrite;
    o.iord     = bus.IorD;
    o.regdst   = bus.RegDst;
    o.memtoreg = bus.MemtoReg;
    o.srca     = bus.ALUSrcA;
    o.srcb     = bus.ALUSrcB;
    o.pcsrc    = bus.PCSrc;
    o.alu      = bus.ALUControl;
    return o;
  endfunction

  // Control word each state should present, taken from the state's listed signals.
  function automatic outs_t expect_outs(input logic [3:0] st, input logic zero, input logic [2:0] alu_r);
    outs_t o;
    o = '0;
    o.alu = 3'b010;
    case (st)
      4'd0:  begin o.ir = 1'b1; o.pcen = 1'b1; o.srcb = 2'b01; end
      4'd1:  o.srcb = 2'b11;
      4'd2:  begin o.srca = 1'b1; o.srcb = 2'b10; end
      4'd3:  o.iord = 1'b1;
      4'd4:  begin o.memtoreg = 1'b1; o.regw = 1'b1; end
      4'd5:  begin o.iord = 1'b1; o.memw = 1'b1; end
      4'd6:  begin o.srca = 1'b1; o.alu = alu_r; end
      4'd7:  begin o.regdst = 1'b1; o.regw = 1'b1; end
      4'd8:  begin o.srca = 1'b1; o.pcsrc = 2'b01; o.pcen = zero; o.alu = 3'b110; end
      4'd9:  begin o.srca = 1'b1; o.srcb = 2'b10; end
      4'd10: o.regw = 1'b1;
      4'd11: begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
      4'd12: begin o.srca = 1'b1; o.pcsrc = 2'b01; o.pcen = ~zero; o.alu = 3'b110; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] funct);
    case (funct)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Instruction-level model: the state walk each opcode takes, FETCH first.
  task automatic model_seq(input logic [5:0] op, output int len, output logic [23:0] seq);
    case (op)
      6'b100011: begin len = 5; seq = 24'h043210; end
      6'b101011: begin len = 4; seq = 24'h005210; end
      6'b000000: begin len = 4; seq = 24'h007610; end
      6'b000100: begin len = 3; seq = 24'h000810; end
      6'b001000: begin len = 4; seq = 24'h00A910; end
      6'b000010: begin len = 3; seq = 24'h000B10; end
`ifdef MC_BNE_EN
      6'b000101: begin len = 3; seq = 24'h000C10; end
`endif
      default:   begin len = 2; seq = 24'h000010; end
    endcase
  endtask

  task automatic compare_state(input string name, input logic [3:0] want);
    n_cmp++;
    if (bus.State !== want) begin
      n_bad++;
      $display("FAIL %s state: got %0d want %0d", name, bus.State, want);
    end
  endtask

  task automatic compare_outs(input string name, input outs_t want);
    outs_t got;
    got = actual_outs();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s outputs in state %0d: got %04h want %04h", name, bus.State, got, want);
    end
  endtask

  task automatic cycle_check(input string name, input logic [3:0] st, input logic zero, input logic [2:0] alu_r);
    bus.Zero = zero;
    @(negedge CLK);
    compare_state(name, st);
    compare_outs(name, expect_outs(st, zero, alu_r));
    @(posedge CLK);
    #1;
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] funct, input logic zero,
                           input int len, input logic [23:0] seq, input logic [2:0] alu_r);
    bus.Op    = op;
    bus.Funct = funct;
    for (int i = 0; i < len; i++) begin
      cycle_check(name, seq[4*i +: 4], zero, alu_r);
    end
  endtask

  vec_t tbl[13];
  logic [5:0] rand_ops[8];

  initial begin
    tbl[0]  = '{"lw",        6'b100011, 6'b000000, 1'b0, 5, 24'h043210, 3'b010};
    tbl[1]  = '{"sw",        6'b101011, 6'b000000, 1'b1, 4, 24'h005210, 3'b010};
    tbl[2]  = '{"r_sub",     6'b000000, 6'b100010, 1'b0, 4, 24'h007610, 3'b110};
    tbl[3]  = '{"r_slt",     6'b000000, 6'b101010, 1'b1, 4, 24'h007610, 3'b111};
    tbl[4]  = '{"r_and",     6'b000000, 6'b100100, 1'b0, 4, 24'h007610, 3'b000};
    tbl[5]  = '{"r_or",      6'b000000, 6'b100101, 1'b0, 4, 24'h007610, 3'b001};
    tbl[6]  = '{"r_badfn",   6'b000000, 6'b111111, 1'b0, 4, 24'h007610, 3'b010};
    tbl[7]  = '{"beq_taken", 6'b000100, 6'b000000, 1'b1, 3, 24'h000810, 3'b010};
    tbl[8]  = '{"beq_not",   6'b000100, 6'b000000, 1'b0, 3, 24'h000810, 3'b010};
    tbl[9]  = '{"j",         6'b000010, 6'b000000, 1'b0, 3, 24'h000B10, 3'b010};
    tbl[10] = '{"addi",      6'b001000, 6'b000000, 1'b1, 4, 24'h00A910, 3'b010};
    tbl[11] = '{"unknown",   6'b111111, 6'b000000, 1'b1, 2, 24'h000010, 3'b010};
`ifdef MC_BNE_EN
    tbl[12] = '{"bne_taken", 6'b000101, 6'b000000, 1'b0, 3, 24'h000C10, 3'b010};
`else
    tbl[12] = '{"bne_off",   6'b000101, 6'b000000, 1'b0, 2, 24'h000010, 3'b010};
`endif
    rand_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101, 6'b111111};

    RST       = 1'b1;
    bus.Op    = 6'b0;
    bus.Funct = 6'b0;
    bus.Zero  = 1'b0;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    compare_state("reset_init", 4'd0);
    compare_outs("reset_init", '0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_instr(tbl[i].name, tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].len, tbl[i].seq, tbl[i].alu_r);
    end

`ifdef MC_BNE_EN
    run_instr("bne_not", 6'b000101, 6'b0, 1'b1, 3, 24'h000C10, 3'b010);
`endif

    // Abort a lw in MEMRD with a two-cycle reset, then restart from FETCH.
    run_instr("rst_mid_lw", 6'b100011, 6'b0, 1'b1, 3, 24'h000210, 3'b010);
    RST = 1'b1;
    @(negedge CLK);
    compare_state("rst_hold1", 4'd3);
    compare_outs("rst_hold1", '0);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    compare_state("rst_hold2", 4'd0);
    compare_outs("rst_hold2", '0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    run_instr("rst_release", 6'b100011, 6'b0, 1'b1, 5, 24'h043210, 3'b010);

    for (int k = 0; k < 200; k++) begin
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      int          len;
      logic [23:0] seq;
      int          pick;
      pick = int'($urandom_range(0, 7));
      op = (pick == 7) ? 6'($urandom_range(0, 63)) : rand_ops[pick];
      funct = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63))
            : {4'b1000, 2'($urandom_range(0, 3))} | ((($urandom_range(0, 3)) == 0) ? 6'b001010 : 6'b000000);
      zero = 1'($urandom_range(0, 1));
      model_seq(op, len, seq);
      run_instr("random", op, funct, zero, len, seq, rtype_alu(funct));
    end

    @(negedge CLK);
    compare_state("final_fetch", 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multicycle MIPS control unit: a Moore FSM plus ALU decoder that sequences the instruction register, PC, memory, register file and ALU muxes across the fetch, decode, execute and writeback steps. It sits beside the datapath. IRWrite drives the instruction register's EN; Op and Funct come from that register's output, fields [31:26] and [5:0].

Parameters:
none (opcodes and state encodings are fixed constants below)

Ports:
CLK  in  1  clock, all state updates on posedge
RST  in  1  synchronous active-high reset
Op  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag
IRWrite  out  1  load instruction register
PCEn  out  1  PC load enable
MemWrite  out  1  memory write
RegWrite  out  1  register file write
IorD  out  1  memory address select (0=PC, 1=ALUOut)
RegDst  out  1  write register select (0=rt, 1=rd)
MemtoReg  out  1  writeback select (0=ALUOut, 1=Data)
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
PCSrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
ALUControl  out  3  ALU function
State  out  4  current state, for debug

Behaviour:
- Decided reset and clock: one clock, CLK. Reset RST is synchronous and active-high. On a posedge with RST=1, the state register is set to FETCH (0).
- While RST=1, all enables (IRWrite, PCEn, MemWrite, RegWrite) are forced to 0, whatever the state. All other outputs are 0 during reset, except State, which shows the registered value.
- A reset asserted mid-instruction aborts the instruction. The first non-reset cycle is FETCH.
- State encoding and next-state rules:
  - FETCH=0 -> DECODE.
  - DECODE=1 -> by Op: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX. Any other Op -> FETCH (no-op, no writes).
  - MEMADR=2 -> MEMRD if lw, MEMWR if sw.
  - MEMRD=3 -> MEMWB=4 -> FETCH.
  - MEMWR=5 -> FETCH.
  - RTYPEEX=6 -> RTYPEWB=7 -> FETCH.
  - BEQEX=8 -> FETCH.
  - ADDIEX=9 -> ADDIWB=10 -> FETCH.
  - JEX=11 -> FETCH.
- Outputs are pure functions of state (Moore), except PCEn. Any signal not listed for a state is 0.
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUOp=00.
  - DECODE: ALUSrcB=11, ALUOp=00.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - RTYPEEX: ALUSrcA=1, ALUOp=10.
  - RTYPEWB: RegDst=1, RegWrite=1.
  - BEQEX: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - ADDIWB: RegWrite=1.
  - JEX: PCSrc=10, PCWrite=1.
- PCEn = PCWrite | (Branch & Zero). This is combinational on Zero within the BEQEX cycle.
- Latency in cycles including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown Op 2.
- ALU decoder (combinational):
  - ALUOp 00 -> 010 (add); ALUOp 01 -> 110 (sub).
  - ALUOp 10 -> by Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other -> 010.
  - ALUOp 11 -> 010.
- Unused state codes 13-15 -> FETCH next cycle, all outputs 0.

Optional Feature:
- Macro: MC_BNE_EN.
- Defined:
  - Op 000101 (bne) in DECODE -> BNEEX=12 -> FETCH.
  - BNEEX outputs: ALUSrcA=1, ALUOp=01, PCSrc=01, internal BranchNE=1.
  - PCEn = PCWrite | (Branch & Zero) | (BranchNE & ~Zero).
- Undefined: Op 000101 is treated as unknown (DECODE -> FETCH), code 12 is unused, and no BranchNE logic is present.

Test Plan:
- Reset: RST=1 for 2 cycles from an arbitrary state, then release -> State=0, IRWrite=1 and PCEn=1 in the first cycle after release; all enables 0 while RST=1.
- lw (Op=100011) -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; IorD=1 in state 3.
- sw (Op=101011) -> sequence 0,1,2,5,0; MemWrite=1 only in state 5; RegWrite never 1.
- R-type Op=000000 with Funct=100010, 101010 and 100100 -> ALUControl=110, 111 and 000 respectively in state 6; RegDst=1 and RegWrite=1 in state 7.
- beq (Op=000100) in state 8: Zero=1 -> PCEn=1 with PCSrc=01; Zero=0 -> PCEn=0. j (Op=000010) -> state 11 with PCEn=1, PCSrc=10.
- Unknown Op=111111 -> 0,1,0 with no writes. With MC_BNE_EN, Op=000101 -> state 12, and PCEn=1 only when Zero=0.
